// File: rtl/cei_mochila_pkg.sv
// rtl/cei_mochila_pkg.sv - shared types and default constants for the TMR recovery controller
package cei_mochila_pkg;

  typedef enum logic [2:0] {
    TMR_OFF    = 3'd0,
    TMR_ACTIVE = 3'd1,
    TMR_HALT   = 3'd2,
    TMR_RESYNC = 3'd3,
    TMR_FATAL  = 3'd4
  } tmr_state_e;

  localparam int TMR_NHARTS        = 3;
  localparam int TMR_ERR_THRESHOLD = 4;
  localparam int TMR_HALT_TIMEOUT  = 256;
  localparam int TMR_CNT_W         = 8;

endpackage

// File: rtl/tmr_err_counter.sv
// rtl/tmr_err_counter.sv - saturating per-hart error counter, clear has priority over increment
module tmr_err_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/tmr_recovery_ctrl.sv
// rtl/tmr_recovery_ctrl.sv - TMR cluster sequencer: voter gating, halt/resync handshake, fault tracking
module tmr_recovery_ctrl
  import cei_mochila_pkg::*;
#(
  parameter int NHARTS        = TMR_NHARTS,
  parameter int ERR_THRESHOLD = TMR_ERR_THRESHOLD,
  parameter int HALT_TIMEOUT  = TMR_HALT_TIMEOUT,
  parameter int CNT_W         = TMR_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tmr_en_i,
  input  logic                    clr_cnt_i,
  input  logic                    voter_error_i,
  input  logic [NHARTS-1:0]       voter_error_id_i,
  output logic                    voter_enable_o,
  output logic [NHARTS-1:0]       halt_req_o,
  input  logic [NHARTS-1:0]       halted_i,
  output logic                    resync_req_o,
  input  logic                    resync_done_i,
  output logic [NHARTS-1:0]       faulty_o,
  output logic [NHARTS*CNT_W-1:0] err_cnt_o,
  output logic                    irq_o,
  output logic                    fatal_o,
  output logic [2:0]              state_o
);

  localparam int TW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [TW-1:0]    TMO_LAST = TW'(HALT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   THR      = (CNT_W+1)'(ERR_THRESHOLD);

  tmr_state_e        state_q, state_d;
  logic [NHARTS-1:0] faulty_q, faulty_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              irq_q;
  logic              err_acc;
  logic [NHARTS-1:0] inc;
  logic [NHARTS-1:0] over_thr;
  logic              all_ack;
  logic              multi_fault;
  logic [CNT_W-1:0]  cnt [NHARTS];

  assign err_acc = (state_q == TMR_ACTIVE) && voter_error_i;
  assign inc     = err_acc ? voter_error_id_i : '0;

  // over_thr looks at the value each counter takes this edge, so a hart
  // crossing the threshold is excluded from halt_req on the first HALT cycle.
  for (genvar h = 0; h < NHARTS; h++) begin : g_cnt
    tmr_err_counter #(.W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (inc[h]),
      .clr_i (clr_cnt_i),
      .cnt_o (cnt[h])
    );
    assign err_cnt_o[h*CNT_W +: CNT_W] = cnt[h];
    assign over_thr[h] = !clr_cnt_i &&
      (({1'b0, cnt[h]} + {{CNT_W{1'b0}}, (inc[h] && (cnt[h] != CNT_MAX))}) >= THR);
  end

  assign all_ack = ((halted_i & ~faulty_q) == ~faulty_q);

  always_comb begin : pop
    int unsigned nf;
    nf = 0;
    for (int h = 0; h < NHARTS; h++) begin
      nf = nf + 32'(faulty_q[h]);
    end
    multi_fault = (nf >= 2);
  end

  always_comb begin
    state_d  = state_q;
    faulty_d = faulty_q;
    tmo_d    = '0;
    case (state_q)
      TMR_OFF: begin
        if (tmr_en_i) state_d = TMR_ACTIVE;
      end
      TMR_ACTIVE: begin
        if (voter_error_i) begin
          state_d  = TMR_HALT;
          faulty_d = faulty_q | over_thr;
        end else if (!tmr_en_i) begin
          state_d = TMR_OFF;
        end
      end
      TMR_HALT: begin
        tmo_d = tmo_q + 1'b1;
        if (multi_fault) begin
          state_d = TMR_FATAL;
        end else if (all_ack) begin
          state_d = TMR_RESYNC;
        end else if (tmo_q == TMO_LAST) begin
          faulty_d = faulty_q | (~halted_i & ~faulty_q);
          state_d  = TMR_RESYNC;
        end
      end
      TMR_RESYNC: begin
        if (multi_fault) begin
          state_d = TMR_FATAL;
        end else if (resync_done_i) begin
          state_d = TMR_ACTIVE;
        end
      end
      TMR_FATAL: state_d = TMR_FATAL;
      default:   state_d = TMR_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= TMR_OFF;
      faulty_q <= '0;
      tmo_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      faulty_q <= faulty_d;
      tmo_q    <= tmo_d;
      irq_q    <= err_acc;
    end
  end

  always_comb begin
    halt_req_o = '0;
    if ((state_q == TMR_HALT) || (state_q == TMR_RESYNC)) begin
      halt_req_o = ~faulty_q;
    end else if (state_q == TMR_FATAL) begin
      halt_req_o = '1;
    end
  end

  assign voter_enable_o = (state_q == TMR_ACTIVE);
  assign resync_req_o   = (state_q == TMR_RESYNC);
  assign fatal_o        = (state_q == TMR_FATAL);
  assign faulty_o       = faulty_q;
  assign irq_o          = irq_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// tb/tb_tmr_recovery_ctrl.sv - directed vector bench for tmr_recovery_ctrl
module tb_tmr_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, clr, err, done;
  logic [2:0]  id, halted;
  logic        ven, rreq, irq, fatal;
  logic [2:0]  hreq, faulty, st;
  logic [23:0] cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tmr_recovery_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .tmr_en_i         (en),
    .clr_cnt_i        (clr),
    .voter_error_i    (err),
    .voter_error_id_i (id),
    .voter_enable_o   (ven),
    .halt_req_o       (hreq),
    .halted_i         (halted),
    .resync_req_o     (rreq),
    .resync_done_i    (done),
    .faulty_o         (faulty),
    .err_cnt_o        (cnt),
    .irq_o            (irq),
    .fatal_o          (fatal),
    .state_o          (st)
  );

  typedef struct {
    logic        rst, en, clr, err;
    logic [2:0]  id, halted;
    logic        done;
    logic        e_ven;
    logic [2:0]  e_hreq;
    logic        e_rreq;
    logic [2:0]  e_faulty;
    logic        e_irq, e_fatal;
    logic [2:0]  e_st;
    logic [23:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic c, input logic er,
                     input logic [2:0] i, input logic [2:0] hl, input logic d,
                     input logic x_ven, input logic [2:0] x_hreq, input logic x_rreq,
                     input logic [2:0] x_f, input logic x_irq, input logic x_fat,
                     input logic [2:0] x_st, input logic [23:0] x_cnt);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c; v.err = er; v.id = i; v.halted = hl; v.done = d;
    v.e_ven = x_ven; v.e_hreq = x_hreq; v.e_rreq = x_rreq; v.e_faulty = x_f;
    v.e_irq = x_irq; v.e_fatal = x_fat; v.e_st = x_st; v.e_cnt = x_cnt;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({ven, hreq, rreq, faulty, irq, fatal, st, cnt});
  endfunction

  task automatic idle();
    rst = 0; en = 0; clr = 0; err = 0; id = 0; halted = 0; done = 0;
  endtask

  initial begin
    idle();
    rst = 1;

    // rst en clr err id halted done | ven hreq rreq faulty irq fatal st cnt
    add(1,0,0,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h0);
    add(0,0,0,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h0);
    add(0,1,0,0,3'd0,3'd0,0, 1,3'd0,0,3'd0,0,0,3'd1,24'h0);
    add(0,1,0,0,3'd0,3'd0,0, 1,3'd0,0,3'd0,0,0,3'd1,24'h0);
    add(0,1,0,1,3'd2,3'd0,0, 0,3'd7,0,3'd0,1,0,3'd2,24'h000100);
    add(0,1,0,0,3'd0,3'd7,0, 0,3'd7,1,3'd0,0,0,3'd3,24'h000100);
    add(0,1,0,0,3'd0,3'd7,0, 0,3'd7,1,3'd0,0,0,3'd3,24'h000100);
    add(0,1,0,0,3'd0,3'd7,1, 1,3'd0,0,3'd0,0,0,3'd1,24'h000100);
    add(0,0,0,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h000100);
    add(0,0,1,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h0);
    add(0,1,0,0,3'd0,3'd0,0, 1,3'd0,0,3'd0,0,0,3'd1,24'h0);
    for (int k = 1; k <= 3; k++) begin
      add(0,1,0,1,3'd4,3'd0,0, 0,3'd7,0,3'd0,1,0,3'd2,24'(k << 16));
      add(0,1,0,0,3'd0,3'd7,0, 0,3'd7,1,3'd0,0,0,3'd3,24'(k << 16));
      add(0,1,0,0,3'd0,3'd7,1, 1,3'd0,0,3'd0,0,0,3'd1,24'(k << 16));
    end
    // fourth error on hart 2 crosses the threshold
    add(0,1,0,1,3'd4,3'd0,0, 0,3'd3,0,3'd4,1,0,3'd2,24'h040000);
    add(0,1,0,0,3'd0,3'd3,0, 0,3'd3,1,3'd4,0,0,3'd3,24'h040000);
    add(0,1,0,0,3'd0,3'd3,1, 1,3'd0,0,3'd4,0,0,3'd1,24'h040000);
    add(0,1,1,1,3'd1,3'd0,0, 0,3'd3,0,3'd4,1,0,3'd2,24'h0);
    add(0,1,0,0,3'd0,3'd3,0, 0,3'd3,1,3'd4,0,0,3'd3,24'h0);
    add(1,1,0,0,3'd0,3'd3,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h0);
    add(0,0,0,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h0);
    add(0,1,0,0,3'd0,3'd0,0, 1,3'd0,0,3'd0,0,0,3'd1,24'h0);
    add(0,0,0,1,3'd7,3'd0,0, 0,3'd7,0,3'd0,1,0,3'd2,24'h010101);
    add(0,0,0,0,3'd0,3'd7,0, 0,3'd7,1,3'd0,0,0,3'd3,24'h010101);
    add(0,0,0,0,3'd0,3'd7,1, 1,3'd0,0,3'd0,0,0,3'd1,24'h010101);
    add(0,0,0,0,3'd0,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h010101);
    add(0,0,0,1,3'd7,3'd0,0, 0,3'd0,0,3'd0,0,0,3'd0,24'h010101);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; clr = tbl[i].clr; err = tbl[i].err;
      id = tbl[i].id; halted = tbl[i].halted; done = tbl[i].done;
      step();
      chk($sformatf("vec%0d", i), outs(),
          64'({tbl[i].e_ven, tbl[i].e_hreq, tbl[i].e_rreq, tbl[i].e_faulty,
               tbl[i].e_irq, tbl[i].e_fatal, tbl[i].e_st, tbl[i].e_cnt}));
    end

    // halt timeout on hart 0, then a threshold fault on hart 1 escalates to FATAL
    idle(); rst = 1; step(); rst = 0;
    en = 1; step();
    err = 1; id = 3'b001; step(); err = 0; id = 0;
    halted = 3'b110;
    for (int i = 1; i <= 255; i++) step();
    chk("tmo_hold_state", 64'(st), 64'd2);
    chk("tmo_hold_faulty", 64'(faulty), 64'd0);
    step();
    chk("tmo_fire", 64'({st, faulty, hreq, rreq}), 64'({3'd3, 3'b001, 3'b110, 1'b1}));
    done = 1; step(); done = 0;
    chk("tmo_resume", 64'({st, faulty, ven}), 64'({3'd1, 3'b001, 1'b1}));
    for (int k = 1; k <= 4; k++) begin
      err = 1; id = 3'b010; step(); err = 0; id = 0;
      if (k < 4) begin
        step();
        done = 1; step(); done = 0;
      end
    end
    chk("fault2_halt", 64'({st, faulty, hreq}), 64'({3'd2, 3'b011, 3'b100}));
    step();
    chk("fatal_entry", 64'({st, fatal, hreq, ven}), 64'({3'd4, 1'b1, 3'b111, 1'b0}));
    halted = 3'b111; done = 1; step(); step(); done = 0;
    chk("fatal_sticky", 64'({st, fatal, rreq, cnt}), 64'({3'd4, 1'b1, 1'b0, 24'h000401}));

    // counter saturation on hart 2
    idle(); rst = 1; step(); rst = 0;
    en = 1; halted = 3'b111; step();
    for (int k = 1; k <= 256; k++) begin
      err = 1; id = 3'b100; step(); err = 0; id = 0;
      if (k == 256) chk("sat_irq", 64'(irq), 64'd1);
      step();
      done = 1; step(); done = 0;
    end
    chk("sat_cnt", 64'(cnt), 64'h00ff0000);
    chk("sat_state", 64'({st, faulty, fatal}), 64'({3'd1, 3'b100, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
